add_accumulator: RTL and testbench

- Downstream consumer of the registered W-bit add stage.
- Accepts a stream of sums over a valid/ready handshake and accumulates N consecutive sums into a widened total.
- Presents each window result, with its sample count, on a registered valid/ready output.
- An optional flush closes a partial window early.

---
 rtl/add_accumulator_if.sv | 28 ++
 rtl/add_accumulator.sv | 123 ++++++++++++
 tb/tb_add_accumulator.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/add_accumulator_if.sv
// Handshake bundle between the add stage, the window accumulator and its consumer.
// W is the sample width and N the window length; AW/CW follow from them.
interface add_accumulator_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int AW = W + $clog2(N);
  localparam int CW = $clog2(N + 1);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic [CW-1:0] out_count;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/add_accumulator.sv
// Sums N consecutive samples into a widened total with an early-close flush.
// Define ACCUM_AVG_EN to report total >> $clog2(N) instead of the raw total.
module add_accumulator #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  add_accumulator_if.slave    bus
);
  localparam int AW = W + $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam int SH = $clog2(N);

  generate
    if (N < 2) begin : g_bad_n
      $error("add_accumulator: N must be at least 2");
    end
`ifdef ACCUM_AVG_EN
    if ((1 << SH) != N) begin : g_bad_avg_n
      $error("add_accumulator: averaging needs N to be a power of two");
    end
`endif
  endgenerate

  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flush_pend_q, flush_pend_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] out_data_q, out_data_d;
  logic [CW-1:0] out_count_q, out_count_d;

  logic          out_free;
  logic          in_ready;
  logic          in_xfer;
  logic          last_slot;
  logic          fire;
  logic [AW-1:0] sum;
  logic [AW-1:0] result;
  logic [CW-1:0] cnt_inc;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;

  // Handshake decode, window arithmetic and completion decision.
  always_comb begin
    out_free  = !out_valid_q || bus.out_ready;
    last_slot = (cnt_q == CW'(N - 1));
    // in_ready depends only on state and out_ready, never on in_valid.
    in_ready  = !flush_pend_q && !(last_slot && !out_free);
    in_xfer   = bus.in_valid && in_ready;
    if (in_xfer) begin
      sum = acc_q + AW'(bus.in_data);
    end else begin
      sum = acc_q;
    end
    cnt_inc = cnt_q + {{(CW - 1){1'b0}}, in_xfer};
`ifdef ACCUM_AVG_EN
    result = sum >> SH;
`else
    result = sum;
`endif
    // A flush only counts when there is at least one sample to report.
    fire = (in_xfer && last_slot) ||
           ((bus.flush || flush_pend_q) && ((cnt_q != {CW{1'b0}}) || in_xfer));

    acc_d        = acc_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;

    if (fire && out_free) begin
      acc_d        = {AW{1'b0}};
      cnt_d        = {CW{1'b0}};
      flush_pend_d = 1'b0;
      out_valid_d  = 1'b1;
      out_data_d   = result;
      out_count_d  = cnt_inc;
    end else begin
      if (in_xfer) begin
        acc_d = sum;
        cnt_d = cnt_inc;
      end else begin
        acc_d = acc_q;
        cnt_d = cnt_q;
      end
      // Only a flush can fire while the output is blocked; remember it.
      if (fire) begin
        flush_pend_d = 1'b1;
      end else begin
        flush_pend_d = flush_pend_q;
      end
      if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q        <= {AW{1'b0}};
      cnt_q        <= {CW{1'b0}};
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= {AW{1'b0}};
      out_count_q  <= {CW{1'b0}};
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
    end
  end
endmodule

// File: tb/tb_add_accumulator.sv
// Directed and mixed-traffic bench for add_accumulator with a window-level reference model.
// Literal expectations follow ACCUM_AVG_EN when it is defined.
module tb_add_accumulator;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SH = $clog2(N);

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  add_accumulator_if #(.W(W), .N(N)) bus ();

  add_accumulator #(.W(W), .N(N)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rep(input int total);
`ifdef ACCUM_AVG_EN
    return total >> SH;
`else
    return total;
`endif
  endfunction

  // Reference model: samples of the open window, pending flush and held result.
  int win[$];
  bit m_pend;
  bit m_ov;
  int m_od;
  int m_oc;

  function automatic bit m_in_ready();
    return !m_pend && !(win.size() == N - 1 && m_ov && !bus.out_ready);
  endfunction

  task automatic m_step();
    bit free;
    bit ix;
    bit fire;
    int s;
    free = !m_ov || bus.out_ready;
    ix   = bus.in_valid && m_in_ready();
    if (ix) win.push_back(int'(bus.in_data));
    fire = (ix && win.size() == N) || ((bus.flush || m_pend) && win.size() > 0);
    if (fire && free) begin
      s = 0;
      foreach (win[i]) s += win[i];
      m_od = rep(s);
      m_oc = win.size();
      m_ov = 1'b1;
      m_pend = 1'b0;
      win.delete();
    end else begin
      if (fire) m_pend = 1'b1;
      if (m_ov && bus.out_ready) m_ov = 1'b0;
    end
  endtask

  initial begin : compare
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        win.delete();
        m_pend = 1'b0;
        m_ov   = 1'b0;
        m_od   = 0;
        m_oc   = 0;
      end
      chk("model in_ready",  int'(bus.in_ready),  int'(m_in_ready()));
      chk("model out_valid", int'(bus.out_valid), int'(m_ov));
      chk("model out_data",  int'(bus.out_data),  m_od);
      chk("model out_count", int'(bus.out_count), m_oc);
      if (reset_n) m_step();
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int d);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = W'(d);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      ok = bus.in_ready;
      tick();
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL send timeout: sample %0d not accepted within 50 cycles", d);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input int data, input int count);
    @(negedge clock);
    chk({name, " valid"}, int'(bus.out_valid), 1);
    chk({name, " data"},  int'(bus.out_data),  rep(data));
    chk({name, " count"}, int'(bus.out_count), count);
  endtask

  task automatic expect_reset_state(input string name);
    @(negedge clock);
    chk({name, " out_valid"}, int'(bus.out_valid), 0);
    chk({name, " out_data"},  int'(bus.out_data),  0);
    chk({name, " out_count"}, int'(bus.out_count), 0);
    chk({name, " in_ready"},  int'(bus.in_ready),  1);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    expect_reset_state("reset");
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    pulse_reset();

    // Basic window and width headroom.
    send(10); send(20); send(30); send(40);
    expect_out("window 100", 100, 4);
    tick();
    send(255); send(255); send(255); send(255);
    expect_out("window 1020", 1020, 4);
    tick();

    // Back-pressure with a held result, then no-bubble reload.
    bus.out_ready = 1'b0;
    send(5); send(5); send(5); send(5);
    send(1); send(2); send(3);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd4;
    @(negedge clock);
    chk("bp in_ready low", int'(bus.in_ready), 0);
    chk("bp held data", int'(bus.out_data), rep(20));
    tick();
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk("bp in_ready high", int'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    expect_out("bp window 10", 10, 4);
    tick();

    // Flush of a partial window, then flush of an empty window.
    send(5); send(7);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    expect_out("flush 12", 12, 2);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    @(negedge clock);
    chk("empty flush no output", int'(bus.out_valid), 0);
    tick();

    // Pending flush while the result register is blocked.
    bus.out_ready = 1'b0;
    send(1); send(1); send(1); send(1);
    send(9);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    @(negedge clock);
    chk("pend in_ready low", int'(bus.in_ready), 0);
    chk("pend held count", int'(bus.out_count), 4);
    tick();
    bus.out_ready = 1'b1;
    tick();
    expect_out("pend flush 9", 9, 1);
    tick();

    // Reset mid-window, then reset with a result pending.
    send(1); send(2); send(3);
    pulse_reset();
    bus.out_ready = 1'b0;
    send(2); send(2); send(2); send(2);
    pulse_reset();
    bus.out_ready = 1'b1;
    send(10); send(20); send(30); send(40);
    expect_out("post-reset window", 100, 4);
    tick();

    // Mixed traffic checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = W'($urandom_range(0, 255));
      bus.flush     = ($urandom_range(0, 7) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
